// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard unit: sequences PC / IF-ID / ID-EX control for load-use, branch/jump,
// instruction-memory wait and multi-cycle mult/div hazards, and counts stall cycles.
module hazard_stall_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_ex_memread,
    input  logic [4:0]  id_ex_rt,
    input  logic        ex_branch_taken,
    input  logic        id_jump,
    input  logic        id_md_start,
    input  logic        id_md_read,
    input  logic        imem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        md_busy,
    output logic [15:0] stall_count
);

    typedef enum logic {RUN, MD_BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] md_cnt;
    logic             lu_haz;
    logic             md_haz;
    logic             md_accept;

    assign lu_haz = id_ex_memread && (id_ex_rt != 5'd0) &&
                    ((id_ex_rt == id_rs) || (id_uses_rt && (id_ex_rt == id_rt)));
    assign md_haz  = (state == MD_BUSY) && (id_md_start || id_md_read);
    assign md_busy = (state == MD_BUSY);

    // A taken branch squashes the ID instruction, so it may neither stall nor start mult/div.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        md_accept   = 1'b0;
        if (rst) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (!imem_ready || lu_haz || md_haz) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end else if (id_jump) begin
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            md_accept   = id_md_start && (state == RUN);
        end else begin
            md_accept   = id_md_start && (state == RUN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (md_accept) begin
                        state  <= MD_BUSY;
                        md_cnt <= CNT_W'(MD_LATENCY - 1);
                    end
                end
                MD_BUSY: begin
                    if (md_cnt != '0) md_cnt <= md_cnt - 1'b1;
                    else              state  <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= 16'd0;
        else if (!pc_write && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'd1;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline control unit that sequences the IF/ID stage register, the PC and the ID/EX bubble insertion.
- Resolves four hazard sources:
  - load-use data hazards
  - taken branches (resolved in EX) and jumps (resolved in ID)
  - instruction-memory wait states
  - a multi-cycle multiply/divide unit tracked by an internal busy FSM
- Drives the PC write enable, the IF/ID write enable and flush, and the ID/EX flush. Also keeps a stall-cycle performance counter.

Parameters:
- MD_LATENCY, 4, cycles the mult/div unit is busy after an accepted start (>=1).
- CNT_W, 6, width of the mult/div down-counter; must satisfy 2^CNT_W > MD_LATENCY.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- id_ex_memread  in  1  instruction in EX is a load.
- id_ex_rt  in  5  destination rt of the instruction in EX.
- ex_branch_taken  in  1  branch in EX resolved taken.
- id_jump  in  1  ID holds j/jal/jr.
- id_md_start  in  1  ID holds mult/div.
- id_md_read  in  1  ID holds mfhi/mflo.
- imem_ready  in  1  fetch data valid this cycle.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID clear (dominates write).
- id_ex_flush  out  1  zero control into ID/EX (bubble).
- md_busy  out  1  state==MD_BUSY.
- stall_count  out  16  saturating count of cycles with pc_write=0.

Behaviour:
- State: FSM {RUN, MD_BUSY}, md_cnt[CNT_W-1:0], stall_count[15:0]. Control outputs are combinational from state and inputs; no added latency.
- While rst=1:
  - state=RUN, md_cnt=0, stall_count=0.
  - pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, md_busy=0.
  - Reset mid-MD_BUSY abandons the count immediately.
- Internal hazard terms:
  - lu_haz = id_ex_memread & (id_ex_rt!=0) & (id_ex_rt==id_rs | (id_uses_rt & id_ex_rt==id_rt)).
  - md_haz = (state==MD_BUSY) & (id_md_start | id_md_read).
- Output priority, first match wins:
  1. ex_branch_taken: pc_write=1, if_id_flush=1, id_ex_flush=1, if_id_write=0. The ID instruction is squashed: no MD start, and lu/md hazards are ignored.
  2. !imem_ready: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_flush=1. Full front-end freeze.
  3. lu_haz | md_haz: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_flush=1. The ID instruction is held.
  4. id_jump: pc_write=1, if_id_flush=1, id_ex_flush=0. The jump proceeds and the fetched slot is dropped.
  5. Otherwise: pc_write=1, if_id_write=1, both flushes 0.
- MD accept = id_md_start & state==RUN & priority case 4 or 5 selected.
- FSM transitions:
  - RUN -> MD_BUSY on accept; md_cnt <= MD_LATENCY-1.
  - In MD_BUSY: if md_cnt!=0, md_cnt <= md_cnt-1; if md_cnt==0, next state RUN.
  - md_busy is therefore high for exactly MD_LATENCY cycles after the accept edge.
  - A taken branch does not abort MD_BUSY, because the mult/div instruction is older than the branch.
- stall_count increments on every edge where pc_write=0 and rst=0. It saturates at 0xFFFF with no wrap.
- Simultaneous lu_haz and md_haz give a single stall cycle per cycle. The hold persists until both terms clear.

Test Plan:
- Reset: assert rst mid-MD_BUSY (md_cnt=2) -> outputs immediately pc_write=0, if_id_flush=1, id_ex_flush=1, md_busy=0. After release, state=RUN and stall_count=0.
- Load-use: id_ex_memread=1, id_ex_rt=8, id_rs=8 -> exactly 1 cycle of pc_write=0, if_id_write=0, id_ex_flush=1. Next cycle (memread=0) normal flow. stall_count=1. Repeat with id_ex_rt=0 -> no stall.
- Branch over hazard: ex_branch_taken=1 with lu_haz=1 and id_md_start=1 -> pc_write=1, if_id_flush=1, id_ex_flush=1, and md_busy stays 0 next cycle.
- MD sequencing (MD_LATENCY=4): accept mult at edge T. Then mflo in ID at T+1 -> stalls for cycles T+1..T+4 (md_busy=1). At T+5 mflo proceeds with if_id_write=1. stall_count=4.
- imem wait with jump: imem_ready=0 for 3 cycles while id_jump=1 -> 3 freeze cycles (pc_write=0, if_id_flush=0). Then 1 cycle pc_write=1, if_id_flush=1.
- Saturation: hold imem_ready=0 for 70000 cycles -> stall_count=0xFFFF and holds.
